// File: rtl/zmips_wb_arbiter.sv
// zmips write-back arbiter: round-robin ALU/load share of the regfile write port.
// Optional read-port forwarding of the in-flight write under ZMIPS_WB_FWD_EN.
module zmips_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_stall,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              err_addr31,
  input  logic [ADDR_W-1:0] rd_addr_0,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [DATA_W-1:0] rf_data_0,
  input  logic [DATA_W-1:0] rf_data_1,
  output logic [DATA_W-1:0] rd_data_0,
  output logic [DATA_W-1:0] rd_data_1
);

  localparam logic [ADDR_W-1:0] R0  = '0;
  localparam logic [ADDR_W-1:0] R31 = ADDR_W'(31);

  logic              last_m;
  logic              xfer;
  logic              is_r0;
  logic              is_r31;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Grant: single requester wins; on a tie the port not served last wins.
  always_comb begin
    a_ready = 1'b0;
    m_ready = 1'b0;
    if (rst_n && !wb_stall) begin
      m_ready = m_valid && (!a_valid || !last_m);
      a_ready = a_valid && (!m_valid || last_m);
    end
  end

  // Mux the granted request and classify its destination.
  always_comb begin
    xfer     = a_ready || m_ready;
    sel_addr = m_ready ? m_addr : a_addr;
    sel_data = m_ready ? m_data : a_data;
    is_r0    = (sel_addr == R0);
    is_r31   = (sel_addr == R31);
  end

  // Output register and priority pointer; r0/r31 writes are swallowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr         <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      err_addr31 <= 1'b0;
      last_m     <= 1'b0;
    end else begin
      wr         <= xfer && !is_r0 && !is_r31;
      err_addr31 <= xfer && is_r31;
      if (xfer) last_m <= m_ready;
      if (xfer && !is_r0 && !is_r31) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end

`ifdef ZMIPS_WB_FWD_EN
  // Bypass the registered write to matching read ports.
  always_comb begin
    rd_data_0 = rf_data_0;
    rd_data_1 = rf_data_1;
    if (wr && wr_addr == rd_addr_0) rd_data_0 = wr_data;
    if (wr && wr_addr == rd_addr_1) rd_data_1 = wr_data;
  end
`else
  logic unused_rd;
  assign unused_rd = ^{rd_addr_0, rd_addr_1};

  // No forwarding: raw regfile data passes straight through.
  always_comb begin
    rd_data_0 = rf_data_0;
    rd_data_1 = rf_data_1;
  end
`endif

endmodule

// File: tb/tb_zmips_wb_arbiter.sv
// Directed bench for zmips_wb_arbiter.
// Inputs change on the falling edge; outputs sampled 1ns after an edge.
module tb_zmips_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_stall;
  logic        a_valid, a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        m_valid, m_ready;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        wr;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        err_addr31;
  logic [4:0]  rd_addr_0, rd_addr_1;
  logic [31:0] rf_data_0, rf_data_1;
  logic [31:0] rd_data_0, rd_data_1;

  int checks = 0;
  int errors = 0;

  zmips_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_addr(a_addr), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_addr(m_addr), .m_data(m_data),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .err_addr31(err_addr31),
    .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .rf_data_0(rf_data_0), .rf_data_1(rf_data_1),
    .rd_data_0(rd_data_0), .rd_data_1(rd_data_1)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({wr, wr_addr, wr_data, err_addr31} !== 39'd0) begin
      errors++;
      $display("FAIL reset_init: wr=%0b addr=%0d data=%h err=%0b, want all 0",
               wr, wr_addr, wr_data, err_addr31);
    end
    rst_n = 1'b1;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hAB;
    @(posedge clk); #1;
    checks++;
    if (wr !== 1'b1 || wr_addr !== 5'd3) begin
      errors++;
      $display("FAIL reset_pre_wr: wr=%0b addr=%0d, want 1/3", wr, wr_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wr, wr_addr, wr_data, err_addr31} !== 39'd0) begin
      errors++;
      $display("FAIL reset_async: wr=%0b addr=%0d data=%h err=%0b, want all 0",
               wr, wr_addr, wr_data, err_addr31);
    end
    checks++;
    if (a_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_a_ready: got %0b want 0", a_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (a_ready !== 1'b0 || wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: a_ready=%0b wr=%0b want 0/0", a_ready, wr);
    end
    @(negedge clk);
    a_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_alu();
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (a_ready !== 1'b1 || m_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: a=%0b m=%0b want 1/0", a_ready, m_ready);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    checks++;
    if (wr !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_wr: wr=%0b addr=%0d data=%h want 1/5/deadbeef",
               wr, wr_addr, wr_data);
    end
    @(posedge clk); #1;
    checks++;
    if (wr !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: wr=%0b want 0", wr);
    end
  endtask

  task automatic test_contention();
    logic       exp_m [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [4:0] exp_a [4] = '{5'd2, 5'd1, 5'd2, 5'd1};
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
    m_valid = 1'b1; m_addr = 5'd2; m_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (m_ready !== exp_m[i] || a_ready !== !exp_m[i]) begin
        errors++;
        $display("FAIL contend_grant[%0d]: m=%0b a=%0b want m=%0b",
                 i, m_ready, a_ready, exp_m[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (wr !== 1'b1 || wr_addr !== exp_a[i]
          || wr_data !== (exp_m[i] ? 32'h22 : 32'h11)) begin
        errors++;
        $display("FAIL contend_wr[%0d]: wr=%0b addr=%0d data=%h want addr %0d",
                 i, wr, wr_addr, wr_data, exp_a[i]);
      end
      @(negedge clk);
    end
    a_valid = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic test_filter();
    @(negedge clk);
    m_valid = 1'b1; m_addr = 5'd0; m_data = 32'h1;
    #1;
    checks++;
    if (m_ready !== 1'b1) begin
      errors++;
      $display("FAIL filter_r0_ready: got %0b want 1", m_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (wr !== 1'b0 || err_addr31 !== 1'b0) begin
      errors++;
      $display("FAIL filter_r0: wr=%0b err=%0b want 0/0", wr, err_addr31);
    end
    @(negedge clk);
    m_valid = 1'b0;
    a_valid = 1'b1; a_addr = 5'd31; a_data = 32'h2;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL filter_r31_ready: got %0b want 1", a_ready);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    checks++;
    if (wr !== 1'b0 || err_addr31 !== 1'b1) begin
      errors++;
      $display("FAIL filter_r31: wr=%0b err=%0b want 0/1", wr, err_addr31);
    end
    @(posedge clk); #1;
    checks++;
    if (wr !== 1'b0 || err_addr31 !== 1'b0 || wr_addr !== 5'd1) begin
      errors++;
      $display("FAIL filter_after: wr=%0b err=%0b addr=%0d want 0/0/1",
               wr, err_addr31, wr_addr);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    wb_stall = 1'b1;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (a_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready[%0d]: got %0b want 0", i, a_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (wr !== 1'b0) begin
        errors++;
        $display("FAIL stall_wr[%0d]: got %0b want 0", i, wr);
      end
      @(negedge clk);
    end
    wb_stall = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: a_ready=%0b want 1", a_ready);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    checks++;
    if (wr !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'h77) begin
      errors++;
      $display("FAIL stall_wr_after: wr=%0b addr=%0d data=%h want 1/7/77",
               wr, wr_addr, wr_data);
    end
  endtask

  task automatic test_forward();
    logic [31:0] exp0;
`ifdef ZMIPS_WB_FWD_EN
    exp0 = 32'h1234;
`else
    exp0 = 32'h0;
`endif
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h1234;
    @(posedge clk); #1;
    a_valid = 1'b0;
    rd_addr_0 = 5'd9; rd_addr_1 = 5'd8;
    rf_data_0 = 32'h0; rf_data_1 = 32'hCAFE;
    #1;
    checks++;
    if (rd_data_0 !== exp0) begin
      errors++;
      $display("FAIL fwd_rd0: got %h want %h", rd_data_0, exp0);
    end
    checks++;
    if (rd_data_1 !== 32'hCAFE) begin
      errors++;
      $display("FAIL fwd_rd1: got %h want cafe", rd_data_1);
    end
    @(posedge clk); #1;
    checks++;
    if (rd_data_0 !== 32'h0) begin
      errors++;
      $display("FAIL fwd_idle: got %h want 0", rd_data_0);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_addr = 5'(10 + i); a_data = 32'(100 + i);
      @(posedge clk); #1;
      checks++;
      if (wr !== 1'b1 || wr_addr !== 5'(10 + i) || wr_data !== 32'(100 + i)) begin
        errors++;
        $display("FAIL b2b[%0d]: wr=%0b addr=%0d data=%0d want 1/%0d/%0d",
                 i, wr, wr_addr, wr_data, 10 + i, 100 + i);
      end
      @(negedge clk);
    end
    a_valid = 1'b0;
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    m_valid = 1'b1; m_addr = 5'd4; m_data = 32'h44;
    @(posedge clk); #1;
    m_valid = 1'b0;
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
    m_valid = 1'b1; m_addr = 5'd2; m_data = 32'h22;
    #1;
    checks++;
    if (a_ready !== 1'b1 || m_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_after_m: a=%0b m=%0b want 1/0", a_ready, m_ready);
    end
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (m_ready !== 1'b1 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_after_reset: m=%0b a=%0b want 1/0", m_ready, a_ready);
    end
    @(negedge clk);
    a_valid = 1'b0;
    m_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wb_stall = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    m_valid = 1'b0; m_addr = '0; m_data = '0;
    rd_addr_0 = '0; rd_addr_1 = '0;
    rf_data_0 = '0; rf_data_1 = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single_alu();
    test_contention();
    test_filter();
    test_stall();
    test_forward();
    test_back_to_back();
    test_reset_priority();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zmips_wb_arbiter.md
# zmips_wb_arbiter

Write-back arbiter for the zmips register file's single write port. It shares that port between the ALU result path and the load unit using valid/ready handshakes and round-robin priority, and registers the winning write. It filters writes to r0 and to the unimplemented r31. Optionally, it forwards the in-flight write to the two read ports. It sits between the execute/memory stages and `zmips_regfile`, and is the only block that drives the regfile's `wr`, `wr_addr` and `wr_data`.

## Interface
- `DATA_W`, 32: data width.
- `ADDR_W`, 5: register address width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wb_stall`  in  1  when high, both readies are low and nothing is accepted.
- `a_valid`  in  1  ALU write request.
- `a_ready`  out  1  ALU request accepted this cycle.
- `a_addr`  in  ADDR_W  ALU destination register.
- `a_data`  in  DATA_W  ALU result.
- `m_valid`, `m_ready`, `m_addr`, `m_data`: load-unit request, same shape and meaning as the `a_*` ports.
- `wr`  out  1  regfile write enable.
- `wr_addr`  out  ADDR_W  regfile write address.
- `wr_data`  out  DATA_W  regfile write data.
- `err_addr31`  out  1  one-cycle pulse when an accepted request targets r31.
- `rd_addr_0`, `rd_addr_1`  in  ADDR_W  regfile read addresses (used by forwarding).
- `rf_data_0`, `rf_data_1`  in  DATA_W  raw regfile read data.
- `rd_data_0`, `rd_data_1`  out  DATA_W  read data delivered to the datapath.

## Operation
- Transfer on a port: `x_valid && x_ready` at a rising edge.
- Readies are combinational from valids, `wb_stall` and the priority pointer `last_m`.
  - `wb_stall` high: `a_ready = m_ready = 0`.
  - Exactly one of `a_valid`/`m_valid` high: that port's ready is 1.
  - Both valid: M is granted if `last_m == 0`, otherwise A is granted.
  - At most one ready is high per cycle.
- `last_m` updates only on a transfer: set to 1 on an M transfer, 0 on an A transfer. Its reset value is 0, so M wins the first tie.
- Output register, loaded on every edge:
  - Transfer with address 1..30: `wr = 1`, `wr_addr` and `wr_data` take the granted request's values.
  - Transfer with address 0: request is accepted and discarded; `wr = 0`.
  - Transfer with address 31: request is accepted and discarded; `wr = 0`, `err_addr31 = 1` for one cycle.
  - No transfer: `wr = 0`, `err_addr31 = 0`; `wr_addr`/`wr_data` hold their previous values.
- Requesters hold `valid`, `addr` and `data` stable until they receive ready. A requester that drops `valid` before ready loses its request with no side effect.

## Timing
- Reset (asynchronous, `rst_n` low):
  - `wr = 0`, `wr_addr = 0`, `wr_data = 0`, `err_addr31 = 0`, `last_m = 0`.
  - `a_ready` and `m_ready` are low while `rst_n` is low.
  - Any in-flight write is cancelled.
- Latency: a request accepted at edge N drives `wr` during cycle N→N+1; the regfile commits it at edge N+1.
- Throughput: one write per cycle, sustained.
- Both requesters held valid with no stall: grants alternate M, A, M, A…. Neither port waits more than one cycle.
- `wb_stall` is sampled combinationally. If it rises in the same cycle as a valid, nothing is accepted; a write already registered still completes.
- Reset released mid-burst: the first grant after release follows `last_m = 0` priority.

## Configuration
- `ZMIPS_WB_FWD_EN` defined:
  - `rd_data_k = wr_data` when `wr && wr_addr == rd_addr_k` (k = 0, 1).
  - Otherwise `rd_data_k = rf_data_k`.
  - Addresses 0 and 31 never forward, because `wr` is never high for them.
- `ZMIPS_WB_FWD_EN` not defined:
  - `rd_data_k = rf_data_k`; no comparators are built.
  - The `rd_addr_*` inputs are unused.

## Test plan
- Reset: assert `rst_n = 0` mid-cycle with `a_valid = 1` → `wr`, `wr_addr`, `wr_data`, `err_addr31` all 0 immediately; `a_ready = 0` while reset is held.
- Single ALU write: `a_valid = 1`, `a_addr = 5`, `a_data = 0xDEADBEEF` → `a_ready = 1`; the next cycle `wr = 1`, `wr_addr = 5`, `wr_data = 0xDEADBEEF`; regfile r5 reads `0xDEADBEEF` after the following edge.
- Contention: both ports valid for 4 cycles (A to r1 = 0x11, M to r2 = 0x22, each held until accepted, then re-issued) → grants M, A, M, A; `wr_addr` sequence 2, 1, 2, 1.
- Filtering: M writes r0 = 0x1, then A writes r31 = 0x2 → both accepted; `wr` stays 0; `err_addr31` pulses for exactly one cycle after the r31 transfer.
- Stall: `wb_stall = 1` for 3 cycles with `a_valid = 1` → `a_ready = 0` and `wr = 0` throughout; the write to r7 appears one cycle after the stall releases.
- Forwarding (with `ZMIPS_WB_FWD_EN`): while `wr = 1`, `wr_addr = 9`, `wr_data = 0x1234`, drive `rd_addr_0 = 9`, `rd_addr_1 = 8`, `rf_data_0 = 0` → `rd_data_0 = 0x1234` and `rd_data_1 = rf_data_1`. Without the macro → `rd_data_0 = 0`.
